// File: rtl/strip_frame_scheduler.sv
// Round-robin arbiter for the shared BRAM read port, with a double-buffered frame bank.
// Banks swap only at a common frame boundary, and all strips then restart together on frame_go.
module strip_frame_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int LOCAL_AW     = 10,
    parameter int ADDR_WIDTH   = 13,
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*LOCAL_AW-1:0]  req_addr,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [DATA_WIDTH-1:0]        rsp_data,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    input  logic [DATA_WIDTH-1:0]        mem_dout,
    input  logic [NUM_REQ-1:0]           frame_done,
    output logic                         frame_go,
    input  logic                         swap_req,
    output logic                         swap_ack,
    output logic                         display_bank,
    output logic                         write_bank
);
    localparam int IDW    = $clog2(NUM_REQ);
    localparam int STAGES = 1 + READ_LATENCY;

    logic [IDW-1:0]                rr, cand, gnt_idx;
    logic                          gnt_any;
    logic [NUM_REQ-1:0]            grant, done_seen;
    logic [STAGES:1][NUM_REQ-1:0]  vld_pipe;
    logic [LOCAL_AW-1:0]           gnt_local;
    logic                          swap_pending, boundary, apply_swap;

    // First valid requester at or after rr; NUM_REQ is a power of two so the index wraps for free.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = rr;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = rr + IDW'(k);
            if (!gnt_any && req_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
        if (rst) gnt_any = 1'b0;
        grant = '0;
        if (gnt_any) grant[gnt_idx] = 1'b1;
    end

    assign gnt_local  = req_addr[gnt_idx*LOCAL_AW +: LOCAL_AW];
    assign req_ready  = grant;
    assign rsp_valid  = vld_pipe[STAGES];
    assign rsp_data   = mem_dout;
    assign write_bank = ~display_bank;
    assign boundary   = &done_seen;
    assign apply_swap = boundary & swap_pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr           <= '0;
            mem_addr     <= '0;
            vld_pipe     <= '0;
            display_bank <= 1'b0;
            swap_pending <= 1'b0;
            swap_ack     <= 1'b0;
            frame_go     <= 1'b0;
            done_seen    <= '1;
        end else begin
            if (gnt_any) begin
                rr       <= gnt_idx + 1'b1;
                mem_addr <= {display_bank, gnt_idx, gnt_local};
            end
            // The id travels alongside the BRAM read so the strobe lines up with mem_dout.
            vld_pipe     <= {vld_pipe[STAGES-1:1], grant};
            frame_go     <= boundary;
            swap_ack     <= apply_swap;
            if (apply_swap) display_bank <= ~display_bank;
            // A new request arriving on the boundary survives the clear.
            swap_pending <= swap_req | (swap_pending & ~boundary);
            done_seen    <= boundary ? '0 : (done_seen | frame_done);
        end
    end
endmodule

// File: tb/tb_strip_frame_scheduler.sv
// Bench for strip_frame_scheduler: directed frame/swap scenarios, then random traffic.
// A reference model predicts grants and frame state; a scoreboard checks the read responses.
module tb_strip_frame_scheduler;
    localparam int N   = 4;
    localparam int LAW = 10;
    localparam int AW  = 13;
    localparam int DW  = 8;
    localparam int RL  = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req_valid = '0;
    logic [N*LAW-1:0] req_addr = '0;
    logic [N-1:0]     req_ready, rsp_valid;
    logic [DW-1:0]    rsp_data;
    logic [AW-1:0]    mem_addr;
    logic [DW-1:0]    mem_dout;
    logic [N-1:0]     frame_done = '0;
    logic             frame_go, swap_req = 1'b0, swap_ack, display_bank, write_bank;

    always #5 clk = ~clk;

    strip_frame_scheduler #(.NUM_REQ(N), .LOCAL_AW(LAW), .ADDR_WIDTH(AW),
                            .DATA_WIDTH(DW), .READ_LATENCY(RL)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .mem_addr(mem_addr), .mem_dout(mem_dout), .frame_done(frame_done),
        .frame_go(frame_go), .swap_req(swap_req), .swap_ack(swap_ack),
        .display_bank(display_bank), .write_bank(write_bank));

    // BRAM model with a two-cycle read latency
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] d1;
    always @(posedge clk) begin
        d1       <= mem[mem_addr];
        mem_dout <= d1;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        int          id;
        logic [DW-1:0] data;
    } rsp_t;
    rsp_t exp_q[$];

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic ok, input longint act, input longint expv);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, expv, cyc);
    endtask

    // Reference model state
    int            rr_m = 0;
    logic          bank_m = 1'b0, pend_m = 1'b0;
    logic [N-1:0]  done_m = '1;
    logic          exp_go = 1'b0, exp_ack = 1'b0;
    logic [AW-1:0] exp_addr = '0;
    logic          have_exp = 1'b0;

    task automatic step(input logic r, input logic [N-1:0] v, input logic [N*LAW-1:0] a,
                        input logic [N-1:0] fd, input logic sw);
        int            g;
        logic [AW-1:0] ad;
        logic [N-1:0]  exp_rdy;
        @(negedge clk);
        #1;
        if (have_exp) begin
            chk("frame_go", frame_go == exp_go, longint'(frame_go), longint'(exp_go));
            chk("swap_ack", swap_ack == exp_ack, longint'(swap_ack), longint'(exp_ack));
            chk("display_bank", display_bank == bank_m, longint'(display_bank), longint'(bank_m));
            chk("write_bank", write_bank == !bank_m, longint'(write_bank), longint'(!bank_m));
            chk("mem_addr", mem_addr == exp_addr, longint'(mem_addr), longint'(exp_addr));
        end
        rst = r; req_valid = v; req_addr = a; frame_done = fd; swap_req = sw;
        #1;
        exp_rdy = '0;
        if (r) begin
            rr_m = 0; bank_m = 1'b0; pend_m = 1'b0; done_m = '1;
            exp_go = 1'b0; exp_ack = 1'b0; exp_addr = '0;
            exp_q.delete();
        end else begin
            g = -1;
            for (int k = 0; k < N; k++) begin
                int j = (rr_m + k) % N;
                if (g < 0 && v[j]) g = j;
            end
            if (g >= 0) begin
                exp_rdy[g] = 1'b1;
                ad = AW'((int'(bank_m) << (AW-1)) + (g << LAW) + int'(a[g*LAW +: LAW]));
                exp_addr = ad;
                exp_q.push_back('{cyc + 1 + RL, g, mem[ad]});
                rr_m = (g + 1) % N;
            end
            exp_go  = (done_m == '1);
            exp_ack = 1'b0;
            if (done_m == '1) begin
                if (pend_m) begin
                    bank_m  = !bank_m;
                    exp_ack = 1'b1;
                    pend_m  = 1'b0;
                end
                done_m = '0;
            end else begin
                done_m = done_m | fd;
            end
            if (sw) pend_m = 1'b1;
        end
        chk("req_ready", req_ready == exp_rdy, longint'(req_ready), longint'(exp_rdy));
        have_exp = 1'b1;
    endtask

    // Scoreboard monitor
    rsp_t         mon_e;
    logic [N-1:0] mon_oh;
    always @(negedge clk) begin
        if (rsp_valid != '0) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 1'b0, longint'(rsp_valid), 0);
            end else begin
                mon_e  = exp_q.pop_front();
                mon_oh = N'(1) << mon_e.id;
                chk("rsp_valid", rsp_valid == mon_oh, longint'(rsp_valid), longint'(mon_oh));
                chk("rsp_cycle", mon_e.due == cyc, longint'(cyc), longint'(mon_e.due));
                chk("rsp_data", rsp_data == mon_e.data, longint'(rsp_data), longint'(mon_e.data));
            end
        end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            mon_e = exp_q.pop_front();
            chk("rsp_missing", 1'b0, 0, longint'(mon_e.id));
        end
    end

    logic [N*LAW-1:0] a;
    logic [N-1:0]     fd;

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
        repeat (3) step(1'b1, '0, '0, '0, 1'b0);
        step(1'b0, '0, '0, '0, 1'b0);
        repeat (2) step(1'b0, '0, '0, '0, 1'b0);

        // drivers 0 and 2 alternate
        a = '0;
        a[0*LAW +: LAW] = LAW'(5);
        a[2*LAW +: LAW] = LAW'(9);
        repeat (4) step(1'b0, 4'b0101, a, '0, 1'b0);
        repeat (4) step(1'b0, '0, '0, '0, 1'b0);

        // all drivers back to back
        for (int i = 0; i < 8; i++) begin
            a = (N*LAW)'({$urandom, $urandom});
            step(1'b0, 4'b1111, a, '0, 1'b0);
        end
        repeat (4) step(1'b0, '0, '0, '0, 1'b0);

        // mid-frame swap, then frame_done from 3,1,0,2
        step(1'b0, '0, '0, '0, 1'b1);
        step(1'b0, '0, '0, '0, 1'b0);
        step(1'b0, '0, '0, 4'b1000, 1'b0);
        step(1'b0, '0, '0, 4'b0010, 1'b0);
        step(1'b0, '0, '0, 4'b0001, 1'b0);
        step(1'b0, '0, '0, 4'b0100, 1'b0);
        step(1'b0, '0, '0, '0, 1'b0);
        step(1'b0, 4'b0010, '0, '0, 1'b0);
        repeat (4) step(1'b0, '0, '0, '0, 1'b0);

        // two requests in one frame, then one landing on the boundary itself
        step(1'b0, '0, '0, '0, 1'b1);
        step(1'b0, '0, '0, '0, 1'b1);
        step(1'b0, '0, '0, 4'b1111, 1'b0);
        step(1'b0, '0, '0, '0, 1'b1);
        step(1'b0, '0, '0, '0, 1'b0);
        step(1'b0, '0, '0, 4'b1111, 1'b0);
        repeat (3) step(1'b0, '0, '0, '0, 1'b0);

        // reset with reads in flight and a pending swap
        a = (N*LAW)'({$urandom, $urandom});
        step(1'b0, '0, '0, 4'b1111, 1'b1);
        step(1'b0, 4'b0011, a, '0, 1'b0);
        step(1'b0, 4'b0011, a, '0, 1'b0);
        step(1'b1, 4'b0011, a, '0, 1'b0);
        step(1'b1, '0, '0, '0, 1'b0);
        step(1'b0, '0, '0, '0, 1'b0);
        repeat (5) step(1'b0, '0, '0, '0, 1'b0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            a = (N*LAW)'({$urandom, $urandom});
            for (int b = 0; b < N; b++) fd[b] = ($urandom_range(7) == 0);
            step($urandom_range(99) == 0, N'($urandom), a, fd, $urandom_range(15) == 0);
        end
        repeat (6) step(1'b0, '0, '0, '0, 1'b0);
        chk("drain", exp_q.size() == 0, longint'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/strip_frame_scheduler.md
Name: strip_frame_scheduler

Overview:
- Sequences the LED-strip refresh datapath.
- Shares the single BRAM read port (port A) between NUM_REQ strip drivers using round-robin arbitration.
- Double-buffers frame memory: drivers read the display bank while the SPI side writes the other bank.
- Swaps banks only at a common frame boundary, then releases all strips together with a frame_go pulse.

Parameters:
- NUM_REQ, 4, number of strip-driver requesters; power of two.
- LOCAL_AW, 10, per-driver byte address width within one bank.
- ADDR_WIDTH, 13, BRAM address width; must equal 1 + log2(NUM_REQ) + LOCAL_AW.
- DATA_WIDTH, 8, BRAM data width.
- READ_LATENCY, 2, cycles from mem_addr change to matching mem_dout.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-driver read request.
- req_addr  input  NUM_REQ*LOCAL_AW  per-driver local byte address; driver i uses slice [i*LOCAL_AW +: LOCAL_AW].
- req_ready  output  NUM_REQ  one-hot grant, combinational; transfer occurs when req_valid[i] and req_ready[i] are both high.
- rsp_valid  output  NUM_REQ  one-hot read-data-valid strobe.
- rsp_data  output  DATA_WIDTH  read data; equals mem_dout.
- mem_addr  output  ADDR_WIDTH  BRAM port A address, registered.
- mem_dout  input  DATA_WIDTH  BRAM port A read data.
- frame_done  input  NUM_REQ  one-cycle pulse from driver i after its last response of a frame.
- frame_go  output  1  one-cycle pulse; all drivers start a new frame.
- swap_req  input  1  one-cycle pulse from the SPI side: the write bank is complete.
- swap_ack  output  1  one-cycle pulse in the cycle the bank toggles.
- display_bank  output  1  bank currently read by the drivers.
- write_bank  output  1  always ~display_bank; the SPI side writes this bank.

Behaviour:
- Reset values:
  - req_ready = 0, rsp_valid = 0, mem_addr = 0, frame_go = 0, swap_ack = 0.
  - display_bank = 0; rr pointer = 0; swap_pending = 0; latency shift line cleared.
  - done_seen = all ones, so frame_go pulses in the first cycle after rst deasserts.
- Arbitration:
  - Each cycle, at most one grant.
  - Search req_valid starting at index rr, wrapping modulo NUM_REQ; grant the first requester found.
  - If no requester is valid, no grant and rr is unchanged.
  - After a grant to index i, rr becomes (i+1) mod NUM_REQ.
  - req_ready is zero in any cycle rst is high.
- Address: on a grant to i in cycle T, mem_addr <= {display_bank, i[log2(NUM_REQ)-1:0], req_addr slice i} at the end of T. With no grant, mem_addr holds its value.
- Response:
  - A one-hot id shift line of depth 1+READ_LATENCY.
  - rsp_valid[i] is high for exactly one cycle, T+1+READ_LATENCY (T+3 by default), and rsp_data is valid in that cycle.
  - Fully pipelined: a grant every cycle yields a response every cycle, in grant order.
- Frame sequencing:
  - frame_done[i] sets done_seen[i].
  - In any cycle where done_seen is all ones:
    - If swap_pending is set: display_bank toggles, swap_ack pulses, and swap_pending clears, all in that same cycle.
    - frame_go pulses, and done_seen clears to zero.
    - The result is a single cycle (E) with done_seen all ones followed by frame_go.
  - A bank toggle affects only grants issued after the toggle cycle. Responses in flight carry their own address, and mem_addr already latched is unchanged.
- Swap request rules:
  - swap_req sets swap_pending.
  - swap_req while swap_pending is already set is absorbed; at most one toggle per frame boundary.
  - swap_req in the same cycle a swap is applied is captured as a new pending swap (the set wins over the clear).
- Protocol errors: a request from driver i while done_seen[i] is set is still served. A repeated frame_done pulse is idempotent.
- Reset mid-operation: all in-flight responses are dropped (no rsp_valid after reset), any pending swap is discarded, and display_bank returns to 0.

Test Plan:
- Release rst -> frame_go high in the first post-reset cycle; display_bank=0, swap_ack=0.
- Drivers 0 and 2 hold req_valid with req_addr 5 and 9, rr=0 -> grants 0,2,0,2 on consecutive cycles; mem_addr=0x0005 then 0x0809; rsp_valid[0] at grant+3 with rsp_data equal to the BRAM model's byte at 0x0005.
- All four drivers request continuously for 8 cycles -> grant order 0,1,2,3,0,1,2,3; one rsp_valid per cycle, ids in the same order, offset by 3 cycles.
- swap_req pulsed mid-frame, then frame_done from drivers 3,1,0,2 on separate cycles -> no toggle until the cycle after driver 2's pulse; then display_bank=1, swap_ack=1 and frame_go=1 in the same cycle; the next grant from driver 1 at local 0 gives mem_addr=0x1400.
- Two swap_req pulses within one frame -> exactly one toggle. A swap_req coincident with swap_ack -> a second toggle at the following boundary.
- Assert rst with 2 reads in flight and swap_pending set -> no rsp_valid afterwards, display_bank=0, and frame_go one cycle after release.
